// File: rtl/psum_requant_pkg.sv
// Shared constants and types for the partial-sum requantization output stage.
package psum_requant_pkg;

    // Lane count is shared with the partial-sum accumulator (3x3 window).
    localparam int LANES = 9;

    // Datapath widths.
    localparam int AW = 32;   // signed accumulator lane
    localparam int MW = 16;   // unsigned scale
    localparam int SW = 5;    // shift amount, 0..31
    localparam int OW = 8;    // signed output activation

    // Lane index width.
    localparam int LW = $clog2(LANES);

    // Internal widths of the requant pipeline.
    localparam int SUMW  = AW + 1;        // bias-added lane
    localparam int PRODW = AW + MW + 2;   // scaled lane

    // Output saturation limits.
    localparam int OUT_MAX = (1 << (OW - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OW - 1));

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/psum_requant_lane.sv
// Three-stage requantization datapath for one lane at a time:
// bias add, scale multiply, rounding shift with ReLU and saturation.
// Each lane carries its own scale/shift/relu/index so vectors can overlap.
module requant_lane
    import psum_requant_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          issue,
    input  logic [AW-1:0] lane_data,
    input  logic [AW-1:0] bias,
    input  logic [MW-1:0] scale,
    input  logic [SW-1:0] shift,
    input  logic          relu_en,
    input  logic [LW-1:0] lane_idx,
    output logic          out_valid,
    output logic [OW-1:0] dout,
    output logic [LW-1:0] out_lane,
    output logic          out_last
);

    localparam logic signed [PRODW:0] SAT_MAX = (PRODW + 1)'(OUT_MAX);
    localparam logic signed [PRODW:0] SAT_MIN = (PRODW + 1)'(OUT_MIN);

    // Stage 1 registers
    logic                   s1_valid;
    logic signed [SUMW-1:0] s1_sum;
    logic [MW-1:0]          s1_scale;
    logic [SW-1:0]          s1_shift;
    logic                   s1_relu;
    logic [LW-1:0]          s1_idx;

    // Stage 2 registers
    logic                    s2_valid;
    logic signed [PRODW-1:0] s2_prod;
    logic [SW-1:0]           s2_shift;
    logic                    s2_relu;
    logic [LW-1:0]           s2_idx;

    // Combinational helpers
    logic signed [SUMW-1:0]  sum_next;
    logic signed [PRODW-1:0] prod_a;
    logic signed [PRODW-1:0] prod_b;
    logic signed [PRODW-1:0] prod_next;
    logic signed [PRODW:0]   rnd_add;
    logic signed [PRODW:0]   rnd_sum;
    logic signed [PRODW:0]   shifted;
    logic signed [PRODW:0]   clipped;
    logic [OW-1:0]           sat_val;

    // Bias add: both operands sign-extended by one bit, so no overflow.
    always_comb begin
        sum_next = $signed({lane_data[AW-1], lane_data}) + $signed({bias[AW-1], bias});
    end

    // Scale multiply: scale is zero-extended so the product is signed x non-negative.
    always_comb begin
        prod_a    = PRODW'(s1_sum);
        prod_b    = $signed({{(PRODW - MW){1'b0}}, s1_scale});
        prod_next = prod_a * prod_b;
    end

    // Round half toward +inf, arithmetic shift, optional ReLU, then saturate.
    always_comb begin
        rnd_add = '0;
        if (s2_shift != '0) begin
            rnd_add[s2_shift - SW'(1)] = 1'b1;
        end
        rnd_sum = $signed({s2_prod[PRODW-1], s2_prod}) + rnd_add;
        shifted = rnd_sum >>> s2_shift;

        if (s2_relu && shifted[PRODW]) begin
            clipped = '0;
        end else begin
            clipped = shifted;
        end

        if (clipped > SAT_MAX) begin
            sat_val = SAT_MAX[OW-1:0];
        end else if (clipped < SAT_MIN) begin
            sat_val = SAT_MIN[OW-1:0];
        end else begin
            sat_val = clipped[OW-1:0];
        end
    end

    // Stage 1: capture the issued lane with its bias sum and parameter sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_scale <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            s1_idx   <= '0;
        end else if (!stall) begin
            s1_valid <= issue;
            if (issue) begin
                s1_sum   <= sum_next;
                s1_scale <= scale;
                s1_shift <= shift;
                s1_relu  <= relu_en;
                s1_idx   <= lane_idx;
            end
        end
    end

    // Stage 2: scaled product and remaining sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_shift <= '0;
            s2_relu  <= 1'b0;
            s2_idx   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod  <= prod_next;
                s2_shift <= s1_shift;
                s2_relu  <= s1_relu;
                s2_idx   <= s1_idx;
            end
        end
    end

    // Stage 3: registered output; data held on bubbles so it stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                dout     <= sat_val;
                out_lane <= s2_idx;
                out_last <= (s2_idx == LW'(LANES - 1));
            end
        end
    end

endmodule

// File: rtl/psum_requant.sv
// Requantization output stage: buffers one accumulator vector with its
// parameters and issues its lanes one per cycle into the requant pipeline.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | vector buffer free; accept next vector when not stalled
// ST_BUSY | issuing buffered lanes 0..LANES-1, one per unstalled cycle
module psum_requant
    import psum_requant_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*AW-1:0] din,
    input  logic [AW-1:0]       bias,
    input  logic [MW-1:0]       scale,
    input  logic [SW-1:0]       shift,
    input  logic                relu_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       dout,
    output logic [LW-1:0]       out_lane,
    output logic                out_last
);

    state_t              state;
    logic [LW-1:0]       lane_cnt;
    logic [LANES*AW-1:0] din_q;
    logic [AW-1:0]       bias_q;
    logic [MW-1:0]       scale_q;
    logic [SW-1:0]       shift_q;
    logic                relu_q;

    logic                stall;
    logic                issue;
    logic [AW-1:0]       lane_data;

    // Backpressure freezes the whole block; no accept or issue while frozen.
    always_comb begin
        stall     = out_valid && !out_ready;
        in_ready  = (state == ST_IDLE) && !stall;
        issue     = (state == ST_BUSY) && !stall;
        lane_data = din_q[int'(lane_cnt) * AW +: AW];
    end

    // FSM, vector buffer and lane counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lane_cnt <= '0;
            din_q    <= '0;
            bias_q   <= '0;
            scale_q  <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else if (!stall) begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        din_q    <= din;
                        bias_q   <= bias;
                        scale_q  <= scale;
                        shift_q  <= shift;
                        relu_q   <= relu_en;
                        lane_cnt <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (lane_cnt == LW'(LANES - 1)) begin
                        lane_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        lane_cnt <= lane_cnt + LW'(1);
                    end
                end
                default: begin
                    lane_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    requant_lane u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .issue     (issue),
        .lane_data (lane_data),
        .bias      (bias_q),
        .scale     (scale_q),
        .shift     (shift_q),
        .relu_en   (relu_q),
        .lane_idx  (lane_cnt),
        .out_valid (out_valid),
        .dout      (dout),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_psum_requant.sv
// Self-checking bench for psum_requant: directed cases plus randomized
// vectors against an arithmetic reference model with an expected-output queue.
module tb_psum_requant;
    import psum_requant_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*AW-1:0] din;
    logic [AW-1:0]       bias;
    logic [MW-1:0]       scale;
    logic [SW-1:0]       shift;
    logic                relu_en;
    logic                out_valid;
    logic                out_ready;
    logic [OW-1:0]       dout;
    logic [LW-1:0]       out_lane;
    logic                out_last;

    always #5 clk = ~clk;

    psum_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .bias      (bias),
        .scale     (scale),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    typedef struct {
        int val;
        int lane;
        bit last;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   acc_cyc[$];
    int   last_cnt = 0;
    int   last_xfer_lane = -1;
    int   got_val[LANES];
    int   got_cyc[LANES];
    bit   rand_ready = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the requant rules.
    function automatic int ref_lane(input longint acc, input longint b, input longint sc,
                                    input int sh, input bit relu);
        longint v;
        v = (acc + b) * sc;
        if (sh != 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic push_model();
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            e.val  = ref_lane(longint'($signed(din[i*AW +: AW])), longint'($signed(bias)),
                              longint'(scale), int'(shift), relu_en);
            e.lane = i;
            e.last = (i == LANES - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: observe handshakes before the edge, then advance past it.
    task automatic step();
        bit   acc;
        bit   xfer;
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (acc) begin
            push_model();
            acc_cyc.push_back(cyc);
        end
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout", longint'($signed(dout)), e.val);
                check("out_lane", out_lane, e.lane);
                check("out_last", out_last, e.last);
            end
            if (int'(out_lane) < LANES) begin
                got_val[out_lane] = $signed(dout);
                got_cyc[out_lane] = cyc;
            end
            last_xfer_lane = int'(out_lane);
            if (out_last) last_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(output int acc_at);
        int n0;
        n0 = acc_cyc.size();
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (acc_cyc.size() != n0) break;
        end
        in_valid = 1'b0;
        if (acc_cyc.size() == n0) begin
            check("accept_timeout", 0, 1);
            acc_at = -1;
        end else begin
            acc_at = acc_cyc[$];
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic set_vec(input int b, input int sc, input int sh, input bit r);
        bias    = AW'(b);
        scale   = MW'(sc);
        shift   = SW'(sh);
        relu_en = r;
    endtask

    task automatic set_lane(input int i, input int v);
        din[i*AW +: AW] = v;
    endtask

    int a0, a1, lc0, tmp;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        set_vec(0, 1, 0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_out_lane", out_lane, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Saturation high
        for (int i = 0; i < LANES; i++) set_lane(i, i);
        set_lane(0, 100);
        set_vec(28, 1, 0, 1'b0);
        send(tmp);
        drain();
        check("sat_hi", got_val[0], 127);

        // Saturation low, then ReLU
        set_lane(1, -300);
        set_vec(0, 1, 1, 1'b0);
        send(tmp);
        drain();
        check("sat_lo", got_val[1], -128);
        set_vec(0, 1, 1, 1'b1);
        send(tmp);
        drain();
        check("relu_neg", got_val[1], 0);

        // Rounding
        set_lane(0, 5); set_lane(1, -5); set_lane(2, 2); set_lane(3, 0);
        set_vec(0, 3, 2, 1'b0);
        send(tmp);
        drain();
        check("rnd_p5", got_val[0], 4);
        check("rnd_m5", got_val[1], -4);
        check("rnd_p2", got_val[2], 2);
        check("rnd_0", got_val[3], 0);

        // Latency and ordering: lane k observed in cycle accept+4+k (after edge T+3+k)
        for (int i = 0; i < LANES; i++) set_lane(i, i);
        set_vec(0, 1, 0, 1'b0);
        lc0 = last_cnt;
        send(a0);
        drain();
        for (int k = 0; k < LANES; k++) begin
            check("lat_cycle", got_cyc[k] - a0, 4 + k);
            check("lat_val", got_val[k], k);
        end
        check("lat_last_pulses", last_cnt - lc0, 1);

        // Backpressure while lane 2 is shown
        for (int i = 0; i < LANES; i++) set_lane(i, 10 * i);
        send(tmp);
        for (int k = 0; k < 50; k++) begin
            if (out_valid && out_lane == 2) break;
            step();
        end
        check("bp_reach_lane2", out_lane, 2);
        tmp = int'(in_ready);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_dout", longint'($signed(dout)), 20);
            check("bp_lane", out_lane, 2);
            check("bp_in_ready", in_ready, tmp);
        end
        out_ready = 1'b1;
        drain();
        for (int k = 2; k < LANES - 1; k++) check("bp_no_gap", got_cyc[k+1] - got_cyc[k], 1);

        // Back-to-back vectors with different parameters
        for (int i = 0; i < LANES; i++) set_lane(i, 7 * i - 20);
        set_vec(3, 2, 1, 1'b0);
        lc0 = last_cnt;
        send(a0);
        for (int i = 0; i < LANES; i++) set_lane(i, 31 - 9 * i);
        set_vec(-4, 5, 3, 1'b1);
        send(a1);
        check("b2b_gap", a1 - a0, LANES + 1);
        drain();
        check("b2b_last_pulses", last_cnt - lc0, 2);

        // Reset after lane 4 is output
        for (int i = 0; i < LANES; i++) set_lane(i, i + 1);
        set_vec(0, 1, 0, 1'b0);
        send(tmp);
        last_xfer_lane = -1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_xfer_lane == 4) break;
        end
        check("mid_reached_lane4", last_xfer_lane, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_lane", out_lane, 0);
        check("mid_rst_last", out_last, 0);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("mid_no_leftover", out_valid, 0);
        end
        for (int i = 0; i < LANES; i++) set_lane(i, -3 * i);
        set_vec(1, 2, 0, 1'b0);
        last_xfer_lane = -1;
        send(tmp);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            step();
        end
        check("mid_restart_lane0", out_lane, 0);
        drain();

        // Randomized vectors with random backpressure and idle gaps
        rand_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            for (int i = 0; i < LANES; i++) begin
                case ($urandom_range(0, 2))
                    0: set_lane(i, int'($urandom));
                    1: set_lane(i, int'($urandom_range(0, 4000)) - 2000);
                    default: set_lane(i, int'($urandom_range(0, 200)) - 100);
                endcase
            end
            if ($urandom_range(0, 1) == 0)
                set_vec(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 300)),
                        int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            else
                set_vec(int'($urandom), int'($urandom_range(0, 65535)),
                        int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            send(tmp);
            repeat ($urandom_range(0, 3)) step();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
